fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: three-state sequencer (FETCH / MEM / HALTED)
// holding the PC and the instruction register, and computing next-PC for
// sequential flow, conditional branches, register jumps and JAL.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// PC update to a target whose low two bits are not zero halts the core.
// When it is undefined, the low two bits are cleared and misalign stays 0.

package fetch_unit_pkg;
  typedef enum logic [2:0] {
    PCSRC_PC4,
    PCSRC_BEQ,
    PCSRC_BNE,
    PCSRC_REG,
    PCSRC_JAL
  } pcsrc_t;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        dhit,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic        halt_in,
  input  pcsrc_t      pcsrc,
  input  logic        zero,
  input  logic [31:0] rdat1,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] instr,
  output logic [31:0] npc,
  output logic        dREN,
  output logic        dWEN,
  output logic        halt,
  output logic        misalign
);

  typedef enum logic [1:0] {
    FETCH,
    MEM,
    HALTED
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] ir, ir_nxt;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] target;
  logic        update;
  logic        trap;

  // Output decode from the current state.
  always_comb begin
    iREN  = (state == FETCH);
    instr = (state == FETCH) ? iload : ir;
    dREN  = (state == MEM) & dREN_in;
    dWEN  = (state == MEM) & dWEN_in;
    halt  = (state == HALTED);
    iaddr = pc;
    npc   = pc + 32'd4;
  end

  // Next-PC target selection from the instruction being executed.
  always_comb begin
    br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    br_tgt = npc + br_off;
    target = npc;
    case (pcsrc)
      PCSRC_PC4: target = npc;
      PCSRC_BEQ: target = zero  ? br_tgt : npc;
      PCSRC_BNE: target = !zero ? br_tgt : npc;
      PCSRC_REG: target = rdat1;
      PCSRC_JAL: target = {npc[31:28], instr[25:0], 2'b00};
      default:   target = npc;
    endcase
  end

  // Sequencer next-state, PC and instruction register update.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    update    = 1'b0;
    trap      = 1'b0;
    case (state)
      FETCH: begin
        if (ihit) begin
          ir_nxt = iload;
          if (halt_in) begin
            state_nxt = HALTED;
          end else if (dREN_in | dWEN_in) begin
            state_nxt = MEM;
          end else begin
            update = 1'b1;
          end
        end
      end
      MEM: begin
        if (dhit) begin
          state_nxt = FETCH;
          update    = 1'b1;
        end
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
    if (update) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      // A misaligned target overrides the normal transition and halts.
      if (target[1:0] != 2'b00) begin
        trap      = 1'b1;
        state_nxt = HALTED;
      end else begin
        pc_nxt = target;
      end
`else
      pc_nxt = target & ~32'd3;
`endif
    end
  end

  // State, PC and instruction register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
      pc    <= PC_INIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      misalign_q <= 1'b0;
    end else if (trap) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0 & trap;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses
// and direct observations; a negedge monitor pops and compares them.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic        dREN_in;
  logic        dWEN_in;
  logic        halt_in;
  pcsrc_t      pcsrc;
  logic        zero;
  logic [31:0] rdat1;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        dREN;
  logic        dWEN;
  logic        halt;
  logic        misalign;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .dhit(dhit),
    .dREN_in(dREN_in), .dWEN_in(dWEN_in), .halt_in(halt_in), .pcsrc(pcsrc),
    .zero(zero), .rdat1(rdat1), .iREN(iREN), .iaddr(iaddr), .instr(instr),
    .npc(npc), .dREN(dREN), .dWEN(dWEN), .halt(halt), .misalign(misalign)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } fetch_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  fetch_t fetch_q[$];
  chk_t   chk_q[$];
  int     tests = 0;
  int     fails = 0;
  fetch_t f;
  chk_t   c;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADDI = 32'h2001_0005;
  localparam logic [31:0] LW   = 32'h8C22_0000;
  localparam logic [31:0] SW   = 32'hAC22_0004;
  localparam logic [31:0] BEQ  = 32'h1000_FFFE;
  localparam logic [31:0] BNE  = 32'h1400_0003;
  localparam logic [31:0] JR   = 32'h0320_0008;
  localparam logic [31:0] JAL  = 32'h0C00_0010;
  localparam logic [31:0] HLT  = 32'hFC00_0000;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on every completed fetch, then drain direct observations.
  always @(negedge CLK) begin
    if (nRST && iREN && ihit) begin
      if (fetch_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fetch_unexpected: got fetch at %h expected none", iaddr);
      end else begin
        f = fetch_q.pop_front();
        cmp("fetch_iaddr", iaddr, f.addr);
        cmp("fetch_npc", npc, f.addr + 32'd4);
        cmp("fetch_instr", instr, f.word);
        cmp("fetch_dreq", {30'd0, dREN, dWEN}, 32'd0);
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      cmp(c.name, c.act, c.exp);
    end
  end

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t e;
    e.name = name;
    e.act  = act;
    e.exp  = exp;
    chk_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] word, input pcsrc_t src, input logic [31:0] addr);
    fetch_t e;
    e.addr = addr;
    e.word = word;
    fetch_q.push_back(e);
    iload = word;
    pcsrc = src;
    ihit  = 1'b1;
    tick();
    ihit  = 1'b0;
  endtask

  task automatic reset_pulse();
    nRST = 1'b0;
    #1;
    expect_eq("rst_iaddr", iaddr, 32'h0);
    expect_eq("rst_iren", {31'd0, iREN}, 32'd1);
    expect_eq("rst_dren", {31'd0, dREN}, 32'd0);
    expect_eq("rst_halt", {31'd0, halt}, 32'd0);
    expect_eq("rst_misalign", {31'd0, misalign}, 32'd0);
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0; ihit = 1'b0; iload = '0; dhit = 1'b0; dREN_in = 1'b0;
    dWEN_in = 1'b0; halt_in = 1'b0; pcsrc = PCSRC_PC4; zero = 1'b0; rdat1 = '0;
    #3;
    expect_eq("init_iaddr", iaddr, 32'h0);
    expect_eq("init_iren", {31'd0, iREN}, 32'd1);
    expect_eq("init_dreq", {30'd0, dREN, dWEN}, 32'd0);
    expect_eq("init_halt", {31'd0, halt}, 32'd0);
    expect_eq("init_misalign", {31'd0, misalign}, 32'd0);
    tick();
    tick();
    nRST = 1'b1;
    tick();
    expect_eq("idle_iaddr", iaddr, 32'h0);

    // Sequential flow.
    fetch(ADDI, PCSRC_PC4, 32'h0);
    expect_eq("addi_iaddr", iaddr, 32'h4);
    fetch(NOP, PCSRC_PC4, 32'h4);

    // Load with delayed data hit; ihit during MEM must be ignored.
    dREN_in = 1'b1;
    fetch(LW, PCSRC_PC4, 32'h8);
    ihit  = 1'b1;
    iload = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dhit = 1'b1;
      expect_eq("lw_iren", {31'd0, iREN}, 32'd0);
      expect_eq("lw_dren", {31'd0, dREN}, 32'd1);
      expect_eq("lw_instr", instr, LW);
      expect_eq("lw_iaddr", iaddr, 32'h8);
      tick();
    end
    ihit = 1'b0; dhit = 1'b0; dREN_in = 1'b0;
    expect_eq("lw_done_iaddr", iaddr, 32'hC);
    expect_eq("lw_done_iren", {31'd0, iREN}, 32'd1);

    // Store with immediate data hit.
    dWEN_in = 1'b1;
    fetch(SW, PCSRC_PC4, 32'hC);
    dhit = 1'b1;
    expect_eq("sw_dreq", {30'd0, dREN, dWEN}, 32'd1);
    tick();
    dhit = 1'b0; dWEN_in = 1'b0;

    // dhit in FETCH without ihit must not move anything.
    dhit = 1'b1;
    tick();
    expect_eq("hold_iaddr", iaddr, 32'h10);
    tick();
    expect_eq("hold_iren", {31'd0, iREN}, 32'd1);
    dhit = 1'b0;

    // Branches.
    zero = 1'b1;
    fetch(BEQ, PCSRC_BEQ, 32'h10);
    expect_eq("beq_taken", iaddr, 32'hC);
    fetch(NOP, PCSRC_PC4, 32'hC);
    zero = 1'b0;
    fetch(BEQ, PCSRC_BEQ, 32'h10);
    expect_eq("beq_not_taken", iaddr, 32'h14);
    fetch(BNE, PCSRC_BNE, 32'h14);
    expect_eq("bne_taken", iaddr, 32'h24);

    // Jumps.
    rdat1 = 32'h0000_0040;
    fetch(JR, PCSRC_REG, 32'h24);
    expect_eq("jr_iaddr", iaddr, 32'h40);
    rdat1 = 32'h1000_0000;
    fetch(JR, PCSRC_REG, 32'h40);
    fetch(JAL, PCSRC_JAL, 32'h1000_0000);
    expect_eq("jal_iaddr", iaddr, 32'h1000_0040);

    // PC wrap at the top of the address space.
    rdat1 = 32'hFFFF_FFFC;
    fetch(JR, PCSRC_REG, 32'h1000_0040);
    fetch(NOP, PCSRC_PC4, 32'hFFFF_FFFC);
    expect_eq("wrap_iaddr", iaddr, 32'h0);
    expect_eq("wrap_npc", npc, 32'h4);

    // Misaligned register jump.
    rdat1 = 32'h0000_0042;
    fetch(JR, PCSRC_REG, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    expect_eq("mis_halt", {31'd0, halt}, 32'd1);
    expect_eq("mis_flag", {31'd0, misalign}, 32'd1);
    expect_eq("mis_iaddr", iaddr, 32'h0);
    expect_eq("mis_iren", {31'd0, iREN}, 32'd0);
`else
    expect_eq("mis_iaddr", iaddr, 32'h40);
    expect_eq("mis_flag", {31'd0, misalign}, 32'd0);
    expect_eq("mis_halt", {31'd0, halt}, 32'd0);
`endif
    tick();
    reset_pulse();

    // Reset in the middle of a MEM operation.
    fetch(NOP, PCSRC_PC4, 32'h0);
    dREN_in = 1'b1;
    fetch(LW, PCSRC_PC4, 32'h4);
    expect_eq("mem_dren", {31'd0, dREN}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    expect_eq("memrst_iaddr", iaddr, 32'h0);
    expect_eq("memrst_dren", {31'd0, dREN}, 32'd0);
    expect_eq("memrst_iren", {31'd0, iREN}, 32'd1);
    tick();
    nRST = 1'b1;
    dREN_in = 1'b0;
    tick();
    expect_eq("post_rst_iren", {31'd0, iREN}, 32'd1);
    expect_eq("post_rst_iaddr", iaddr, 32'h0);

    // Halt is sticky until reset.
    halt_in = 1'b1;
    fetch(HLT, PCSRC_PC4, 32'h0);
    halt_in = 1'b0; ihit = 1'b1; dhit = 1'b1; dREN_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_eq("halt_flag", {31'd0, halt}, 32'd1);
      expect_eq("halt_iren", {31'd0, iREN}, 32'd0);
      expect_eq("halt_dren", {31'd0, dREN}, 32'd0);
      expect_eq("halt_iaddr", iaddr, 32'h0);
      tick();
    end
    ihit = 1'b0; dhit = 1'b0; dREN_in = 1'b0;
    reset_pulse();
    tick();
    expect_eq("unhalt_flag", {31'd0, halt}, 32'd0);

    expect_eq("fetch_q_empty", 32'(fetch_q.size()), 32'd0);
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
